// File: rtl/microseq_pkg.sv
// Shared types for the microprogram sequencer.
package microseq_pkg;

  localparam int unsigned UADDR_W_DEFAULT = 11;

  typedef logic [UADDR_W_DEFAULT-1:0] uaddr_t;

  typedef enum logic [2:0] {
    CMD_NEXT     = 3'd0,
    CMD_JUMP     = 3'd1,
    CMD_CALL     = 3'd2,
    CMD_RET      = 3'd3,
    CMD_BR_T     = 3'd4,
    CMD_BR_F     = 3'd5,
    CMD_DISPATCH = 3'd6,
    CMD_WAIT     = 3'd7
  } microseq_cmd_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_ILLEGAL   = 2'd3
  } err_t;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO: push writes entry[sp], top_o reads entry[sp-1].
module microseq_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 11,
  parameter int unsigned SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [W-1:0]    push_data_i,
  output logic [W-1:0]    top_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [SP_W-1:0] sp_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx  = IDX_W'(sp_q);
  assign rd_idx  = IDX_W'(sp_q - 1'b1);
  assign top_o   = mem_q[rd_idx];
  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign sp_o    = sp_q;

  // Occupancy counter; the caller never pushes and pops together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp_q <= '0;
    end else if (push_i) begin
      sp_q <= sp_q + 1'b1;
    end else if (pop_i) begin
      sp_q <= sp_q - 1'b1;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/microseq.sv
// Microprogram sequencer: next-address mux, call/return stack and trap logic.
module microseq
  import microseq_pkg::*;
#(
  parameter int unsigned UADDR_W     = 11,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned COND_W      = 8,
  parameter logic [UADDR_W-1:0] RESET_UADDR = '0,
  parameter int unsigned CSEL_W = (COND_W > 1) ? $clog2(COND_W) : 1,
  parameter int unsigned SP_W   = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic [2:0]         cmd,
  input  logic [UADDR_W-1:0] load_uaddr,
  input  logic [CSEL_W-1:0]  cond_sel,
  input  logic [COND_W-1:0]  cond,
  input  logic [UADDR_W-1:0] dispatch_uaddr,
  output logic [UADDR_W-1:0] uaddr,
  output logic [SP_W-1:0]    sp,
  output logic               halted,
  output logic [1:0]         err_code
);

  logic [UADDR_W-1:0] uaddr_q, uaddr_d;
  logic               halted_q, halted_d;
  err_t               err_q, err_d;

  logic [UADDR_W-1:0] seq;
  logic [UADDR_W-1:0] stk_top;
  logic               stk_full, stk_empty;
  logic               push, pop;
  logic               cond_bit;
  microseq_cmd_t      cmd_e;

  assign seq   = uaddr_q + 1'b1;
  assign cmd_e = microseq_cmd_t'(cmd);

  microseq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (UADDR_W),
    .SP_W  (SP_W)
  ) u_stack (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (seq),
    .top_o       (stk_top),
    .full_o      (stk_full),
    .empty_o     (stk_empty),
    .sp_o        (sp)
  );

  // Selected condition flag; out-of-range selects read as 0.
  always_comb begin
    cond_bit = 1'b0;
    if (32'(cond_sel) < COND_W) begin
      cond_bit = cond[cond_sel];
    end
  end

  // Next-address and trap decode; halted and stall freeze everything.
  always_comb begin
    uaddr_d  = uaddr_q;
    halted_d = halted_q;
    err_d    = err_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (!halted_q && !stall) begin
      case (cmd_e)
        CMD_NEXT:     uaddr_d = seq;
        CMD_JUMP:     uaddr_d = load_uaddr;
        CMD_CALL: begin
          if (!stk_full) begin
            push    = 1'b1;
            uaddr_d = load_uaddr;
          end else begin
            halted_d = 1'b1;
            err_d    = ERR_OVERFLOW;
          end
        end
        CMD_RET: begin
          if (!stk_empty) begin
            pop     = 1'b1;
            uaddr_d = stk_top;
          end else begin
            halted_d = 1'b1;
            err_d    = ERR_UNDERFLOW;
          end
        end
        CMD_BR_T:     uaddr_d = cond_bit ? load_uaddr : seq;
        CMD_BR_F:     uaddr_d = cond_bit ? seq : load_uaddr;
        CMD_DISPATCH: uaddr_d = dispatch_uaddr;
        CMD_WAIT:     uaddr_d = cond_bit ? seq : uaddr_q;
        default: begin
          halted_d = 1'b1;
          err_d    = ERR_ILLEGAL;
        end
      endcase
    end
  end

  // Sequencer state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uaddr_q  <= RESET_UADDR;
      halted_q <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      uaddr_q  <= uaddr_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign uaddr    = uaddr_q;
  assign halted   = halted_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_microseq.sv
// Directed plus random scoreboard bench for the microprogram sequencer.
module tb_microseq;

  localparam int UW = 11;
  localparam int SD = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall;
  logic [2:0]    cmd;
  logic [UW-1:0] load_uaddr;
  logic [2:0]    cond_sel;
  logic [CW-1:0] cond;
  logic [UW-1:0] dispatch_uaddr;
  logic [UW-1:0] uaddr;
  logic [2:0]    sp;
  logic          halted;
  logic [1:0]    err_code;

  microseq #(
    .UADDR_W     (UW),
    .STACK_DEPTH (SD),
    .COND_W      (CW),
    .RESET_UADDR (11'h000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .cmd            (cmd),
    .load_uaddr     (load_uaddr),
    .cond_sel       (cond_sel),
    .cond           (cond),
    .dispatch_uaddr (dispatch_uaddr),
    .uaddr          (uaddr),
    .sp             (sp),
    .halted         (halted),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [UW-1:0] ua;
    logic [2:0]    sp;
    logic          h;
    logic [1:0]    e;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state
  logic [UW-1:0] m_ua = '0;
  logic [2:0]    m_sp = '0;
  logic          m_h  = 1'b0;
  logic [1:0]    m_e  = '0;
  logic [UW-1:0] m_stk [SD];

  task automatic model_step();
    logic b;
    b = (int'(cond_sel) < CW) ? cond[cond_sel] : 1'b0;
    if (!reset_n) begin
      m_ua = '0; m_sp = '0; m_h = 1'b0; m_e = 2'd0;
    end else if (!m_h && !stall) begin
      case (cmd)
        3'd0: m_ua = m_ua + 1'b1;
        3'd1: m_ua = load_uaddr;
        3'd2: if (int'(m_sp) < SD) begin
                m_stk[m_sp] = m_ua + 1'b1;
                m_sp = m_sp + 1'b1;
                m_ua = load_uaddr;
              end else begin
                m_h = 1'b1; m_e = 2'd1;
              end
        3'd3: if (m_sp != 0) begin
                m_sp = m_sp - 1'b1;
                m_ua = m_stk[m_sp];
              end else begin
                m_h = 1'b1; m_e = 2'd2;
              end
        3'd4: m_ua = b ? load_uaddr : m_ua + 1'b1;
        3'd5: m_ua = b ? m_ua + 1'b1 : load_uaddr;
        3'd6: m_ua = dispatch_uaddr;
        default: m_ua = b ? m_ua + 1'b1 : m_ua;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic st, input logic [2:0] c,
                      input logic [UW-1:0] la, input logic [2:0] cs,
                      input logic [CW-1:0] cd, input logic [UW-1:0] da);
    exp_t e, got;
    reset_n = r; stall = st; cmd = c; load_uaddr = la;
    cond_sel = cs; cond = cd; dispatch_uaddr = da;
    model_step();
    q.push_back('{ua: m_ua, sp: m_sp, h: m_h, e: m_e});
    @(posedge clk);
    #1;
    e   = q.pop_front();
    got = '{ua: uaddr, sp: sp, h: halted, e: err_code};
    n_vec++;
    assert (got === e) else begin
      n_bad++;
      $error("FAIL vec%0d: got ua=%h sp=%0d h=%b e=%0d, want ua=%h sp=%0d h=%b e=%0d",
             n_vec, got.ua, got.sp, got.h, got.e, e.ua, e.sp, e.h, e.e);
    end
  endtask

  task automatic chk(input string tag, input int act, input int want);
    n_vec++;
    assert (act === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, act, want);
    end
  endtask

  localparam logic [2:0] NX = 3'd0, JP = 3'd1, CL = 3'd2, RT = 3'd3,
                         BT = 3'd4, BF = 3'd5, DS = 3'd6, WT = 3'd7;

  initial begin
    // Reset and sequence
    step(0, 0, NX, '0, 0, '0, '0);
    step(0, 0, NX, '0, 0, '0, '0);
    chk("rst_ua", int'(uaddr), 0);
    chk("rst_sp", int'(sp), 0);
    chk("rst_h", int'(halted), 0);
    for (int i = 0; i < 5; i++) step(1, 0, NX, '0, 0, '0, '0);
    chk("seq5", int'(uaddr), 5);
    step(1, 0, JP, 11'h7FF, 0, '0, '0);
    step(1, 0, NX, '0, 0, '0, '0);
    chk("wrap", int'(uaddr), 0);

    // Call/return nesting
    step(1, 0, JP, 11'h010, 0, '0, '0);
    step(1, 0, CL, 11'h100, 0, '0, '0);
    step(1, 0, CL, 11'h200, 0, '0, '0);
    chk("nest_sp", int'(sp), 2);
    step(1, 0, RT, '0, 0, '0, '0);
    chk("ret1_ua", int'(uaddr), 'h101);
    chk("ret1_sp", int'(sp), 1);
    step(1, 0, RT, '0, 0, '0, '0);
    chk("ret2_ua", int'(uaddr), 'h011);
    chk("ret2_sp", int'(sp), 0);

    // Overflow via recursive call
    for (int i = 0; i < 4; i++) step(1, 0, CL, 11'h050, 0, '0, '0);
    chk("full_sp", int'(sp), 4);
    step(1, 0, CL, 11'h060, 0, '0, '0);
    chk("ovf_h", int'(halted), 1);
    chk("ovf_e", int'(err_code), 1);
    chk("ovf_ua", int'(uaddr), 'h050);
    step(1, 0, JP, 11'h123, 0, '0, '0);
    step(1, 0, RT, '0, 0, '0, '0);
    chk("halt_hold", int'(uaddr), 'h050);
    step(0, 0, NX, '0, 0, '0, '0);

    // Underflow
    step(1, 0, RT, '0, 0, '0, '0);
    chk("unf_h", int'(halted), 1);
    chk("unf_e", int'(err_code), 2);
    step(0, 0, NX, '0, 0, '0, '0);

    // Conditional branches
    step(1, 0, BT, 11'h300, 2, 8'b0000_0100, '0);
    chk("brt_taken", int'(uaddr), 'h300);
    step(1, 0, BF, 11'h123, 2, 8'b0000_0100, '0);
    chk("brf_fall", int'(uaddr), 'h301);
    step(1, 0, BT, 11'h123, 3, 8'b0000_0100, '0);
    chk("brt_fall", int'(uaddr), 'h302);
    for (int i = 0; i < 3; i++) step(1, 0, WT, '0, 5, 8'b0000_0100, '0);
    chk("wait_hold", int'(uaddr), 'h302);
    step(1, 0, WT, '0, 5, 8'b0010_0100, '0);
    chk("wait_go", int'(uaddr), 'h303);

    // Stall, dispatch, reset with CALL
    step(1, 1, CL, 11'h400, 0, '0, '0);
    step(1, 1, CL, 11'h400, 0, '0, '0);
    chk("stall_ua", int'(uaddr), 'h303);
    chk("stall_sp", int'(sp), 0);
    step(1, 0, CL, 11'h400, 0, '0, '0);
    chk("call_ua", int'(uaddr), 'h400);
    chk("call_sp", int'(sp), 1);
    step(1, 0, DS, '0, 0, '0, 11'h4A0);
    chk("dispatch", int'(uaddr), 'h4A0);
    step(0, 1, CL, 11'h555, 0, '0, '0);
    chk("rstcall_ua", int'(uaddr), 0);
    chk("rstcall_sp", int'(sp), 0);

    // Random mix against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 40) != 0), ($urandom_range(0, 5) == 0),
           3'($urandom_range(0, 7)), 11'($urandom), 3'($urandom),
           8'($urandom), 11'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
